conv_window_3x3: RTL and testbench

- Consumes the three-row column stream produced by the line buffer and assembles sliding 3x3 convolution windows.
- Each accepted input is one column: three vertically aligned pixels.
- Emits one complete 3x3 window per valid output, with its column index and an end-of-row flag, to the downstream MAC array.
- Valid/ready handshake on both sides, with backpressure to the line-buffer shift control.

---
 rtl/conv_window_3x3_if.sv | 38 +++
 rtl/conv_window_3x3.sv | 186 ++++++++++++++++++
 tb/tb_conv_window_3x3.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_3x3_if.sv
//------------------------------------------------------------------------------
// Module      : conv_window_3x3_if
// Description : Column-stream input and window-stream output handshake bundle
//               for the 3x3 window assembler.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface conv_window_3x3_if #(
  parameter int BIT_DEPTH = 8,
  parameter int COLS      = 28
);
  logic                         in_valid;
  logic                         in_ready;
  logic [BIT_DEPTH-1:0]         in_r1;
  logic [BIT_DEPTH-1:0]         in_r2;
  logic [BIT_DEPTH-1:0]         in_r3;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic [9*BIT_DEPTH-1:0]       out_window;
  logic [$clog2(COLS+2)-1:0]    out_col;
  logic                         out_last;

  // Stimulus / upstream-and-downstream side
  modport master (
    output in_valid, in_r1, in_r2, in_r3, in_last, out_ready,
    input  in_ready, out_valid, out_window, out_col, out_last
  );

  // Window assembler side
  modport slave (
    input  in_valid, in_r1, in_r2, in_r3, in_last, out_ready,
    output in_ready, out_valid, out_window, out_col, out_last
  );
endinterface

`default_nettype wire

// File: rtl/conv_window_3x3.sv
//------------------------------------------------------------------------------
// Module      : conv_window_3x3
// Description : Assembles sliding 3x3 windows from a three-row column stream,
//               with horizontal stride, end-of-row flag and sticky row-length
//               error flags. Define ZERO_PAD_EN for 1-pixel left/right zero
//               padding (adds the PAD_R state).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_window_3x3 #(
  parameter int BIT_DEPTH = 8,
  parameter int COLS      = 28,
  parameter int STRIDE    = 1
) (
  input  logic              clk,
  input  logic              rst,
  conv_window_3x3_if.slave  bus,
  output logic              err_short,
  output logic              err_long
);

`ifdef ZERO_PAD_EN
  localparam int PAD = 1;
  typedef enum logic [1:0] {FILL = 2'd0, STREAM = 2'd1, PAD_R = 2'd2} state_t;
`else
  localparam int PAD = 0;
  typedef enum logic [1:0] {FILL = 2'd0, STREAM = 2'd1} state_t;
`endif

  localparam int PIX_W = 3 * BIT_DEPTH;
  localparam int WIN_W = 9 * BIT_DEPTH;
  localparam int CNT_W = $clog2(COLS + 3);
  localparam int OCW   = $clog2(COLS + 2);
  localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  // A window is complete once this many columns of the row are held
  // (the zero left column stands in for one real column when padding).
  localparam logic [CNT_W-1:0] C_THR    = CNT_W'(3 - PAD);
  localparam logic [CNT_W-1:0] C_COLS   = CNT_W'(COLS);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [PH_W-1:0]  C_PH_MAX = PH_W'(STRIDE - 1);
  localparam logic [PH_W-1:0]  C_PH_ONE = PH_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [PIX_W-1:0]   col0_q, col0_d, col1_q, col1_d, col2_q, col2_d;
  logic               out_valid_q, out_valid_d;
  logic [WIN_W-1:0]   out_window_q, out_window_d;
  logic [OCW-1:0]     out_col_q, out_col_d;
  logic               out_last_q, out_last_d;
  logic               err_short_q, err_short_d;
  logic               err_long_q, err_long_d;

  logic               w_adv, w_in_ready, w_accept, w_pad_shift, w_shift;
  logic               w_over, w_row_last, w_cand, w_emit, w_emit_last;
  logic [PIX_W-1:0]   w_new_col;
  logic [CNT_W-1:0]   w_cnt_next, w_win_col;
  logic [WIN_W-1:0]   w_window;

  // Handshake qualification and candidate window formed by the pending shift
  always_comb begin
    w_adv = !out_valid_q || bus.out_ready;
`ifdef ZERO_PAD_EN
    w_in_ready  = w_adv && (state_q != PAD_R);
    w_pad_shift = w_adv && (state_q == PAD_R);
`else
    w_in_ready  = w_adv;
    w_pad_shift = 1'b0;
`endif
    w_accept   = bus.in_valid && w_in_ready;
    w_shift    = w_accept || w_pad_shift;
    w_new_col  = w_pad_shift ? '0 : {bus.in_r3, bus.in_r2, bus.in_r1};
    w_cnt_next = cnt_q + C_ONE;
    w_win_col  = w_cnt_next - C_THR;
    // Column COLS+1 without in_last is forced to close the row.
    w_over     = w_accept && !bus.in_last && (cnt_q >= C_COLS);
    w_row_last = w_accept && (bus.in_last || w_over);
    w_cand     = w_shift && ((state_q == STREAM) || (w_cnt_next >= C_THR));
    w_emit     = w_cand && (phase_q == '0);
`ifdef ZERO_PAD_EN
    w_emit_last = w_pad_shift;
`else
    w_emit_last = w_row_last;
`endif
    w_window = '0;
    for (int r = 0; r < 3; r++) begin
      w_window[BIT_DEPTH*(3*r+0) +: BIT_DEPTH] = col1_q[BIT_DEPTH*r +: BIT_DEPTH];
      w_window[BIT_DEPTH*(3*r+1) +: BIT_DEPTH] = col2_q[BIT_DEPTH*r +: BIT_DEPTH];
      w_window[BIT_DEPTH*(3*r+2) +: BIT_DEPTH] = w_new_col[BIT_DEPTH*r +: BIT_DEPTH];
    end
  end

  // Next-state: FSM, column shift, stride phase, output register, error flags
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    col0_d       = col0_q;
    col1_d       = col1_q;
    col2_d       = col2_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    out_window_d = out_window_q;
    out_col_d    = out_col_q;
    out_last_d   = out_last_q;
    err_short_d  = err_short_q;
    err_long_d   = err_long_q;

    if (w_shift) begin
      col0_d = col1_q;
      col1_d = col2_q;
      col2_d = w_new_col;
      cnt_d  = w_cnt_next;
      if (w_cnt_next >= C_THR) state_d = STREAM;
    end
    if (w_cand) phase_d = (phase_q == C_PH_MAX) ? '0 : phase_q + C_PH_ONE;
    if (w_emit) begin
      out_valid_d  = 1'b1;
      out_window_d = w_window;
      out_col_d    = w_win_col[OCW-1:0];
      out_last_d   = w_emit_last;
    end
    if (w_over) err_long_d = 1'b1;

`ifdef ZERO_PAD_EN
    if (w_row_last) state_d = PAD_R;
    // Right pad done: restart the row with a zero left column ready in col2.
    if (w_pad_shift) begin
      state_d = FILL;
      cnt_d   = '0;
      phase_d = '0;
      col1_d  = '0;
      col2_d  = '0;
    end
`else
    if (w_row_last) begin
      state_d = FILL;
      cnt_d   = '0;
      phase_d = '0;
      if (w_cnt_next < C_THR) err_short_d = 1'b1;
    end
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      phase_q      <= '0;
      col0_q       <= '0;
      col1_q       <= '0;
      col2_q       <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      out_col_q    <= '0;
      out_last_q   <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      col0_q       <= col0_d;
      col1_q       <= col1_d;
      col2_q       <= col2_d;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      out_col_q    <= out_col_d;
      out_last_q   <= out_last_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_window = out_window_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_last   = out_last_q;
  assign err_short      = err_short_q;
  assign err_long       = err_long_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_3x3.sv
//------------------------------------------------------------------------------
// Module      : tb_conv_window_3x3
// Description : Scoreboard bench for conv_window_3x3 (STRIDE=1 and STRIDE=2
//               instances). Honors ZERO_PAD_EN in its reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_window_3x3;
  localparam int BD   = 8;
  localparam int COLS = 28;
`ifdef ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  typedef struct packed {
    logic [9*BD-1:0] win;
    logic [4:0]      col;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [BD-1:0] in_r1 = '0, in_r2 = '0, in_r3 = '0;
  logic err_short_a, err_long_a, err_short_b, err_long_b;

  wire           m_in_ready   = sel ? ifb.in_ready   : ifa.in_ready;
  wire           m_out_valid  = sel ? ifb.out_valid  : ifa.out_valid;
  wire [9*BD-1:0] m_out_window = sel ? ifb.out_window : ifa.out_window;
  wire [4:0]     m_out_col    = sel ? ifb.out_col    : ifa.out_col;
  wire           m_out_last   = sel ? ifb.out_last   : ifa.out_last;
  wire           m_err_short  = sel ? err_short_b    : err_short_a;
  wire           m_err_long   = sel ? err_long_b     : err_long_a;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int n_win = 0;

  conv_window_3x3_if #(.BIT_DEPTH(BD), .COLS(COLS)) ifa ();
  conv_window_3x3_if #(.BIT_DEPTH(BD), .COLS(COLS)) ifb ();

  assign ifa.in_valid  = in_valid && !sel;
  assign ifa.in_r1     = in_r1;
  assign ifa.in_r2     = in_r2;
  assign ifa.in_r3     = in_r3;
  assign ifa.in_last   = in_last;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid && sel;
  assign ifb.in_r1     = in_r1;
  assign ifb.in_r2     = in_r2;
  assign ifb.in_r3     = in_r3;
  assign ifb.in_last   = in_last;
  assign ifb.out_ready = out_ready;

  conv_window_3x3 #(.BIT_DEPTH(BD), .COLS(COLS), .STRIDE(1)) dut_s1 (
    .clk(clk), .rst(rst), .bus(ifa), .err_short(err_short_a), .err_long(err_long_a));
  conv_window_3x3 #(.BIT_DEPTH(BD), .COLS(COLS), .STRIDE(2)) dut_s2 (
    .clk(clk), .rst(rst), .bus(ifb), .err_short(err_short_b), .err_long(err_long_b));

  always #5 clk = ~clk;

  // Reference pixel at padded column p of a padded row of length m.
  function automatic logic [BD-1:0] ref_pix(input int m, input int p, input int r, input int off);
    if (PAD == 1 && (p == 0 || p == m - 1)) return '0;
    return BD'(off + 10 * r + (p - PAD + 1));
  endfunction

  // Push every window a row of n columns should produce.
  task automatic push_row(input int n, input int off, input int stride, output int cnt);
    exp_t e;
    int m;
    m = n + 2 * PAD;
    cnt = 0;
    for (int k0 = 0; k0 + 2 < m; k0 += stride) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          e.win[BD*(3*r+c) +: BD] = ref_pix(m, k0 + c, r, off);
      e.col  = 5'(k0);
      e.last = (k0 == m - 3);
      sb.push_back(e);
      cnt++;
    end
  endtask

  // One clock: sample handshakes mid-cycle, retire a window against the scoreboard.
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = in_valid && m_in_ready;
    if (m_out_valid && out_ready) begin
      total++;
      n_win++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_window: got col=%0d last=%0d win=%h, none expected",
                 m_out_col, m_out_last, m_out_window);
      end else begin
        e = sb.pop_front();
        if (m_out_window !== e.win || m_out_col !== e.col || m_out_last !== e.last) begin
          bad++;
          $display("FAIL window: got win=%h col=%0d last=%0d, expected win=%h col=%0d last=%0d",
                   m_out_window, m_out_col, m_out_last, e.win, e.col, e.last);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_col(input int k, input int off, input bit last);
    bit acc;
    int guard;
    in_valid = 1'b1;
    in_r1 = BD'(off + k);
    in_r2 = BD'(off + 10 + k);
    in_r3 = BD'(off + 20 + k);
    in_last = last;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 40) begin
      step(acc);
      guard++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: column %0d not accepted after %0d cycles", k, guard);
    end
  endtask

  task automatic send_row(input int n, input int off);
    for (int k = 1; k <= n; k++) send_col(k, off, k == n);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int n);
    bit acc;
    repeat (n) step(acc);
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_out_window !== '0 ||
        m_out_col !== '0 || m_out_last !== 1'b0 || m_err_short !== 1'b0 || m_err_long !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%0d vld=%0d win=%h col=%0d last=%0d es=%0d el=%0d, expected rdy=1 others 0",
               m_in_ready, m_out_valid, m_out_window, m_out_col, m_out_last, m_err_short, m_err_long);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int exp, n0;
    sel = 1'b0;
    n0 = n_win;
    push_row(5, 0, 1, exp);
    send_row(5, 0);
    drain(6);
    total++;
    if (n_win - n0 !== exp || sb.size() != 0) begin
      bad++;
      $display("FAIL basic_count: got %0d windows (%0d left), expected %0d", n_win - n0, sb.size(), exp);
    end
  endtask

  task automatic test_backpressure;
    int exp, n0, k;
    logic [9*BD-1:0] held;
    sel = 1'b0;
    n0 = n_win;
    push_row(5, 0, 1, exp);
    k = 1;
    while (!m_out_valid && k <= 5) begin
      send_col(k, 0, k == 5);
      k++;
    end
    total++;
    if (m_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_start: got out_valid=%0d, expected 1", m_out_valid);
    end
    out_ready = 1'b0;
    held = sb[0].win;
    if (k <= 5) begin
      in_valid = 1'b1;
      in_r1 = BD'(k); in_r2 = BD'(10 + k); in_r3 = BD'(20 + k);
      in_last = (k == 5);
    end
    repeat (4) begin
      @(negedge clk);
      total++;
      if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1 || m_out_window !== held) begin
        bad++;
        $display("FAIL stall_hold: got rdy=%0d vld=%0d win=%h, expected rdy=0 vld=1 win=%h",
                 m_in_ready, m_out_valid, m_out_window, held);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int j = k; j <= 5; j++) send_col(j, 0, j == 5);
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain(6);
    total++;
    if (n_win - n0 !== exp || sb.size() != 0) begin
      bad++;
      $display("FAIL stall_count: got %0d windows (%0d left), expected %0d", n_win - n0, sb.size(), exp);
    end
  endtask

  task automatic test_stride2;
    int exp, n0;
    sel = 1'b1;
    n0 = n_win;
    push_row(7, 40, 2, exp);
    send_row(7, 40);
    drain(6);
    total++;
    if (n_win - n0 !== exp || sb.size() != 0) begin
      bad++;
      $display("FAIL stride2_7col: got %0d windows, expected %0d", n_win - n0, exp);
    end
    n0 = n_win;
    push_row(6, 60, 2, exp);
    send_row(6, 60);
    drain(6);
    total++;
    if (n_win - n0 !== exp || sb.size() != 0) begin
      bad++;
      $display("FAIL stride2_6col: got %0d windows, expected %0d", n_win - n0, exp);
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    int e1, e2, n0;
    sel = 1'b0;
    n0 = n_win;
    push_row(4, 70, 1, e1);
    push_row(3, 100, 1, e2);
    for (int k = 1; k <= 4; k++) send_col(k, 70, k == 4);
    for (int k = 1; k <= 3; k++) send_col(k, 100, k == 3);
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain(6);
    total++;
    if (n_win - n0 !== e1 + e2 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got %0d windows, expected %0d", n_win - n0, e1 + e2);
    end
  endtask

  task automatic test_short;
    int exp, n0;
    sel = 1'b0;
    n0 = n_win;
    push_row(2, 0, 1, exp);
    send_row(2, 0);
    drain(5);
    total++;
    if (n_win - n0 !== exp || m_err_short !== (PAD == 0) || m_err_long !== 1'b0) begin
      bad++;
      $display("FAIL short_row: got %0d windows err_short=%0d err_long=%0d, expected %0d windows err_short=%0d err_long=0",
               n_win - n0, m_err_short, m_err_long, exp, PAD == 0);
    end
    n0 = n_win;
    push_row(3, 30, 1, exp);
    send_row(3, 30);
    drain(5);
    total++;
    if (n_win - n0 !== exp || sb.size() != 0) begin
      bad++;
      $display("FAIL after_short: got %0d windows, expected %0d", n_win - n0, exp);
    end
  endtask

  task automatic test_long;
    int exp, n0;
    sel = 1'b0;
    n0 = n_win;
    push_row(COLS + 1, 0, 1, exp);
    for (int k = 1; k <= COLS + 1; k++) send_col(k, 0, 1'b0);
    in_valid = 1'b0;
    drain(6);
    total++;
    if (n_win - n0 !== exp || sb.size() != 0 || m_err_long !== 1'b1) begin
      bad++;
      $display("FAIL long_row: got %0d windows err_long=%0d, expected %0d windows err_long=1",
               n_win - n0, m_err_long, exp);
    end
  endtask

  task automatic test_async_reset;
    int exp, n0;
    sel = 1'b0;
    send_col(1, 0, 1'b0);
    send_col(2, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (m_out_valid !== 1'b0 || m_out_window !== '0 || m_out_col !== '0 ||
        m_out_last !== 1'b0 || m_err_short !== 1'b0 || m_err_long !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got vld=%0d win=%h col=%0d last=%0d es=%0d el=%0d, expected all 0",
               m_out_valid, m_out_window, m_out_col, m_out_last, m_err_short, m_err_long);
    end
    sb.delete();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = n_win;
    push_row(3, 50, 1, exp);
    send_row(3, 50);
    drain(5);
    total++;
    if (n_win - n0 !== exp || sb.size() != 0) begin
      bad++;
      $display("FAIL post_reset_row: got %0d windows, expected %0d", n_win - n0, exp);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stride2();
    test_back_to_back();
    test_short();
    test_long();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
